// File: rtl/pic_inta_sequencer.sv
// PIC control stage: raises INT, runs the two-pulse 8086 INTA handshake, owns the ISR.
// Optional macro PIC_AEOI_EN: automatic EOI on the trailing INTA edge when aeoi_mode=1.
module pic_inta_sequencer #(
   parameter int VEC_W  = 5,
   parameter int NUM_IR = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 int_req,
   input  logic [2:0]           irq_id,
   input  logic                 inta_n,
   input  logic                 single_mode,
   input  logic                 master_mode,
   input  logic [NUM_IR-1:0]    slave_ir,
   input  logic                 cas_match,
   input  logic [VEC_W-1:0]     icw2_vec,
   input  logic                 eoi_strobe,
   input  logic                 eoi_specific,
   input  logic [2:0]           eoi_level,
   input  logic                 aeoi_mode,
   output logic                 int_out,
   output logic                 freeze,
   output logic [NUM_IR-1:0]    irr_clr,
   output logic [NUM_IR-1:0]    isr,
   output logic [2:0]           cas_id,
   output logic                 cas_id_vld,
   output logic [VEC_W+2:0]     data_out,
   output logic                 data_oe
);

   typedef enum logic [2:0] {IDLE, REQ, ACK1, GAP, ACK2} state_t;

   state_t               state, state_nxt;
   logic                 inta_s1, inta_s2, inta_s3;
   logic                 fall, rise;
   logic [2:0]           id, id_nxt;
   logic                 spur, spur_nxt;
   logic                 own;
   logic                 int_nxt, freeze_nxt, vld_nxt, oe_nxt;
   logic [2:0]           cas_id_nxt;
   logic [VEC_W+2:0]     data_nxt;
   logic [NUM_IR-1:0]    irr_clr_nxt, isr_nxt, set_mask, eoi_clr, aeoi_clr;

   // inta_s3 is the previous synced value, so edges are seen on the synchronized pin only
   assign fall = inta_s3 & ~inta_s2;
   assign rise = ~inta_s3 & inta_s2;

   assign own = single_mode | (master_mode & ~slave_ir[id]) | (~master_mode & cas_match);

`ifndef PIC_AEOI_EN
   logic unused_aeoi;
   assign unused_aeoi = aeoi_mode;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         inta_s1    <= 1'b1;
         inta_s2    <= 1'b1;
         inta_s3    <= 1'b1;
         id         <= 3'd0;
         spur       <= 1'b0;
         int_out    <= 1'b0;
         freeze     <= 1'b0;
         irr_clr    <= '0;
         isr        <= '0;
         cas_id     <= 3'd0;
         cas_id_vld <= 1'b0;
         data_out   <= '0;
         data_oe    <= 1'b0;
      end else begin
         state      <= state_nxt;
         inta_s1    <= inta_n;
         inta_s2    <= inta_s1;
         inta_s3    <= inta_s2;
         id         <= id_nxt;
         spur       <= spur_nxt;
         int_out    <= int_nxt;
         freeze     <= freeze_nxt;
         irr_clr    <= irr_clr_nxt;
         isr        <= isr_nxt;
         cas_id     <= cas_id_nxt;
         cas_id_vld <= vld_nxt;
         data_out   <= data_nxt;
         data_oe    <= oe_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      id_nxt      = id;
      spur_nxt    = spur;
      int_nxt     = int_out;
      freeze_nxt  = freeze;
      irr_clr_nxt = '0;
      cas_id_nxt  = cas_id;
      vld_nxt     = cas_id_vld;
      data_nxt    = data_out;
      oe_nxt      = data_oe;
      set_mask    = '0;
      eoi_clr     = '0;
      aeoi_clr    = '0;

      // EOI is evaluated on the current ISR, so a same-cycle acknowledge set cannot be cleared by it
      if (eoi_strobe) begin
         if (eoi_specific)
            eoi_clr[eoi_level] = 1'b1;
         else
            eoi_clr = isr & (~isr + {{(NUM_IR-1){1'b0}}, 1'b1});
      end

      case (state)
         IDLE: begin
            if (int_req) begin
               int_nxt   = 1'b1;
               state_nxt = REQ;
            end
         end
         REQ: begin
            if (fall) begin
               freeze_nxt = 1'b1;
               int_nxt    = 1'b0;
               state_nxt  = ACK1;
               if (int_req) begin
                  id_nxt                = irq_id;
                  spur_nxt              = 1'b0;
                  set_mask[irq_id]      = 1'b1;
                  irr_clr_nxt[irq_id]   = 1'b1;
               end else begin
                  id_nxt   = 3'd7;
                  spur_nxt = 1'b1;
               end
            end
         end
         ACK1: begin
            if (master_mode && !single_mode && slave_ir[id]) begin
               vld_nxt    = 1'b1;
               cas_id_nxt = id;
            end
            if (rise)
               state_nxt = GAP;
         end
         GAP: begin
            if (fall) begin
               state_nxt = ACK2;
               oe_nxt    = own;
               data_nxt  = {icw2_vec, id};
            end
         end
         ACK2: begin
            if (rise) begin
               oe_nxt     = 1'b0;
               vld_nxt    = 1'b0;
               freeze_nxt = 1'b0;
               state_nxt  = IDLE;
`ifdef PIC_AEOI_EN
               if (aeoi_mode && !spur)
                  aeoi_clr[id] = 1'b1;
`endif
            end
         end
         default: state_nxt = IDLE;
      endcase

      isr_nxt = (isr & ~eoi_clr & ~aeoi_clr) | set_mask;
   end

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Bench for pic_inta_sequencer: directed and randomized INTA handshakes against a behavioural ISR/vector model.
module tb_pic_inta_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       int_req = 1'b0;
   logic [2:0] irq_id = 3'd0;
   logic       inta_n = 1'b1;
   logic       single_mode = 1'b0;
   logic       master_mode = 1'b0;
   logic [7:0] slave_ir = 8'h00;
   logic       cas_match = 1'b0;
   logic [4:0] icw2_vec = 5'd0;
   logic       eoi_strobe = 1'b0;
   logic       eoi_specific = 1'b0;
   logic [2:0] eoi_level = 3'd0;
   logic       aeoi_mode = 1'b0;
   logic       int_out, freeze, cas_id_vld, data_oe;
   logic [7:0] irr_clr, isr, data_out;
   logic [2:0] cas_id;

   int checks = 0;
   int failures = 0;
   logic [7:0] m_isr = 8'h00;

   pic_inta_sequencer #(.VEC_W(5), .NUM_IR(8)) dut (
      .clk(clk), .rst_n(rst_n), .int_req(int_req), .irq_id(irq_id), .inta_n(inta_n),
      .single_mode(single_mode), .master_mode(master_mode), .slave_ir(slave_ir),
      .cas_match(cas_match), .icw2_vec(icw2_vec), .eoi_strobe(eoi_strobe),
      .eoi_specific(eoi_specific), .eoi_level(eoi_level), .aeoi_mode(aeoi_mode),
      .int_out(int_out), .freeze(freeze), .irr_clr(irr_clr), .isr(isr), .cas_id(cas_id),
      .cas_id_vld(cas_id_vld), .data_out(data_out), .data_oe(data_oe)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // model of an EOI command: clear one ISR bit
   function automatic logic [7:0] eoi_model(input logic [7:0] cur, input bit specific, input int lvl);
      logic [7:0] r = cur;
      if (specific) r[lvl] = 1'b0;
      else begin
         for (int i = 0; i < 8; i++)
            if (r[i]) begin
               r[i] = 1'b0;
               break;
            end
      end
      return r;
   endfunction

   task automatic do_eoi(input bit specific, input logic [2:0] lvl);
      eoi_specific = specific;
      eoi_level    = lvl;
      eoi_strobe   = 1'b1;
      @(negedge clk);
      eoi_strobe   = 1'b0;
      m_isr = eoi_model(m_isr, specific, int'(lvl));
      @(negedge clk);
      chk(specific ? "eoi_spec_isr" : "eoi_nonspec_isr", isr, m_isr);
   endtask

   // One complete acknowledge; expectations come from the spec's ownership/vector rules.
   task automatic handshake(input logic [2:0] ir, input bit spur, input bit sng, input bit mst,
                            input logic [7:0] sir, input bit cm, input logic [4:0] vec,
                            input bit aeoi, input bit eoi_fall, input bit rst_gap);
      logic [2:0] idx;
      logic [7:0] irr_or;
      int         irr_cnt;
      bit         oe_seen, vld_exp, own_exp;
      idx     = spur ? 3'd7 : ir;
      vld_exp = mst & ~sng & sir[idx];
      own_exp = sng | (mst & ~sir[idx]) | (~mst & cm);
      single_mode = sng; master_mode = mst; slave_ir = sir; icw2_vec = vec;
      aeoi_mode = aeoi; cas_match = ~cm; irq_id = ir; int_req = 1'b1;
      for (int i = 0; i < 10 && !int_out; i++) @(negedge clk);
      chk("int_raised", int_out, 1'b1);
      if (spur) int_req = 1'b0;
      @(negedge clk);
      // first INTA pulse
      inta_n = 1'b0; irr_or = 8'h00; irr_cnt = 0; oe_seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         eoi_strobe = (eoi_fall && i == 1);
         eoi_specific = 1'b0;
         irr_or |= irr_clr;
         if (irr_clr != 8'h00) irr_cnt++;
         oe_seen |= data_oe;
      end
      if (eoi_fall) m_isr = eoi_model(m_isr, 1'b0, 0);
      if (!spur) m_isr[ir] = 1'b1;
      chk("ack1_int_low", int_out, 1'b0);
      chk("ack1_freeze", freeze, 1'b1);
      chk("ack1_irr_clr", irr_or, spur ? 8'h00 : (8'h01 << ir));
      chk("ack1_irr_cnt", irr_cnt, spur ? 0 : 1);
      chk("ack1_isr", isr, m_isr);
      chk("ack1_cas_vld", cas_id_vld, vld_exp);
      if (vld_exp) chk("ack1_cas_id", cas_id, idx);
      int_req = 1'b0;
      inta_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         oe_seen |= data_oe;
      end
      chk("gap_oe_low", oe_seen, 1'b0);
      chk("gap_cas_vld", cas_id_vld, vld_exp);
      if (rst_gap) begin
         rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         m_isr = 8'h00;
         chk("rst_gap_outputs", {int_out, freeze, irr_clr, isr, cas_id, cas_id_vld, data_out, data_oe}, 32'h0);
         return;
      end
      // second INTA pulse; cas_match settles to its real value before the fall
      cas_match = cm;
      inta_n = 1'b0;
      repeat (6) @(negedge clk);
      chk("ack2_oe", data_oe, own_exp);
      chk("ack2_vector", data_out, {vec, idx});
      chk("ack2_cas_vld", cas_id_vld, vld_exp);
      chk("ack2_freeze", freeze, 1'b1);
      inta_n = 1'b1;
      repeat (6) @(negedge clk);
`ifdef PIC_AEOI_EN
      if (aeoi && !spur) m_isr[ir] = 1'b0;
`endif
      chk("end_oe", data_oe, 1'b0);
      chk("end_cas_vld", cas_id_vld, 1'b0);
      chk("end_freeze", freeze, 1'b0);
      chk("end_int", int_out, 1'b0);
      chk("end_isr", isr, m_isr);
   endtask

   initial begin
      // reset
      repeat (3) @(negedge clk);
      chk("reset_outputs", {int_out, freeze, irr_clr, isr, cas_id, cas_id_vld, data_out, data_oe}, 32'h0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("idle_no_int", int_out, 1'b0);

      // single mode, IR3, vector base 01000 -> 8'h43
      handshake(3'd3, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 5'b01000, 1'b0, 1'b0, 1'b0);
      chk("single_vec43", data_out, 8'h43);
      // spurious: ISR untouched, vector ends in 7
      handshake(3'd5, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 5'b01000, 1'b0, 1'b0, 1'b0);
      // master with slave on IR2, then the same IR without a slave
      handshake(3'd2, 1'b0, 1'b0, 1'b1, 8'h04, 1'b0, 5'b10101, 1'b0, 1'b0, 1'b0);
      handshake(3'd2, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 5'b10101, 1'b0, 1'b0, 1'b0);
      do_eoi(1'b1, 3'd2);
      do_eoi(1'b1, 3'd3);
      // slave mode: not addressed, then addressed
      handshake(3'd1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'b00110, 1'b0, 1'b0, 1'b0);
      handshake(3'd3, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'b00110, 1'b0, 1'b0, 1'b0);
      chk("isr_0a", isr, 8'h0A);
      do_eoi(1'b0, 3'd0);
      chk("nonspec_08", isr, 8'h08);
      do_eoi(1'b1, 3'd3);
      chk("spec_00", isr, 8'h00);
      do_eoi(1'b0, 3'd0);
      // EOI coincident with the ACK1 set of IR0
      handshake(3'd1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0);
      handshake(3'd3, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0);
      handshake(3'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0);
      chk("eoi_ack_same_09", isr, 8'h09);
      // reset during GAP aborts and IDLE ignores INTA afterwards
      handshake(3'd4, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 5'd9, 1'b0, 1'b0, 1'b1);
      inta_n = 1'b0; repeat (6) @(negedge clk);
      inta_n = 1'b1; repeat (6) @(negedge clk);
      chk("post_rst_idle_freeze", freeze, 1'b0);
      chk("post_rst_idle_isr", isr, 8'h00);
`ifdef PIC_AEOI_EN
      handshake(3'd6, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
      chk("aeoi_isr_zero", isr, 8'h00);
`endif
      // randomized handshakes with interleaved EOIs
      for (int n = 0; n < 12; n++) begin
         handshake(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), 1'($urandom),
                   1'($urandom), 8'($urandom), 1'($urandom), 5'($urandom), 1'($urandom),
                   1'b0, 1'b0);
         do_eoi(1'($urandom), 3'($urandom_range(0, 7)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
